// File: rtl/bias_act_sat.sv
// Bias add, optional ReLU and output saturation for scaled features.
// Ports: clk/rst, in_* and out_* valid/ready streams, bias table write, sat counter.
module bias_act_sat #(
  parameter int FEATURE_WIDTH = 32,
  parameter int BIAS_WIDTH    = 32,
  parameter int OUT_WIDTH     = 16,
  parameter int NUM_CH        = 16,
  parameter int CH_AW         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FEATURE_WIDTH-1:0] in_data,
  input  logic                     in_last,
  input  logic                     relu_en,
  input  logic                     bias_we,
  input  logic [CH_AW-1:0]         bias_waddr,
  input  logic [BIAS_WIDTH-1:0]    bias_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_last,
  input  logic                     sat_clr,
  output logic [15:0]              sat_count
);

  localparam int SW = FEATURE_WIDTH + 1;
  localparam int PW = SW - OUT_WIDTH + 1;

  localparam logic signed [SW-1:0] MAX_V =
    {{PW{1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V =
    {{PW{1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MAX =
    {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN =
    {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [BIAS_WIDTH-1:0] bias_q [NUM_CH];
  logic [BIAS_WIDTH-1:0] bias_d [NUM_CH];
  logic [CH_AW-1:0]      ch_q, ch_d;

  logic                  s1_valid_q, s1_valid_d;
  logic signed [SW-1:0]  s1_sum_q, s1_sum_d;
  logic                  s1_relu_q, s1_relu_d;
  logic                  s1_last_q, s1_last_d;

  logic                  out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  out_sat_q, out_sat_d;
  logic [15:0]           sat_q, sat_d;

  logic                  stall, accept, out_xfer;
  logic [BIAS_WIDTH-1:0] bias_rd;
  logic signed [SW-1:0]  sum_in;
  logic signed [SW-1:0]  relu_v;
  logic                  hi, lo;
  logic [OUT_WIDTH-1:0]  clamped;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sat_count = sat_q;

  // Read uses the pre-edge table, so a same-cycle write is not seen.
  assign bias_rd = bias_q[ch_q];
  assign sum_in  =
    $signed({in_data[FEATURE_WIDTH-1], in_data}) +
    $signed({{(SW-BIAS_WIDTH){bias_rd[BIAS_WIDTH-1]}}, bias_rd});

  always_comb begin
    bias_d = bias_q;
    if (bias_we) bias_d[bias_waddr] = bias_wdata;
  end

  always_comb begin
    ch_d = ch_q;
    if (accept) begin
      if (in_last || ch_q == CH_AW'(NUM_CH - 1)) ch_d = '0;
      else ch_d = ch_q + 1'b1;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_relu_d  = s1_relu_q;
    s1_last_d  = s1_last_q;
    if (!stall) begin
      s1_valid_d = in_valid;
      if (accept) begin
        s1_sum_d  = sum_in;
        s1_relu_d = relu_en;
        s1_last_d = in_last;
      end
    end
  end

  // ReLU zero is not a clamp event; only range overflow counts.
  always_comb begin
    relu_v  = (s1_relu_q && s1_sum_q[SW-1]) ? '0 : s1_sum_q;
    hi      = relu_v > MAX_V;
    lo      = relu_v < MIN_V;
    clamped = relu_v[OUT_WIDTH-1:0];
    if (hi) clamped = OUT_MAX;
    else if (lo) clamped = OUT_MIN;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sat_d   = out_sat_q;
    if (!stall) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = clamped;
        out_last_d = s1_last_q;
        out_sat_d  = hi | lo;
      end
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (sat_clr) sat_d = '0;
    else if (out_xfer && out_sat_q && sat_q != 16'hFFFF)
      sat_d = sat_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) bias_q[i] <= '0;
      ch_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_relu_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      sat_q       <= '0;
    end else begin
      bias_q      <= bias_d;
      ch_q        <= ch_d;
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_relu_q   <= s1_relu_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
      sat_q       <= sat_d;
    end
  end

endmodule

// File: tb/tb_bias_act_sat.sv
// Scoreboard bench for bias_act_sat: directed scenarios plus random stream.
// Driver predicts results with plain integer arithmetic; monitor pops and compares.
module tb_bias_act_sat;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        relu_en;
  logic        bias_we;
  logic [3:0]  bias_waddr;
  logic [31:0] bias_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        sat_clr;
  logic [15:0] sat_count;

  bias_act_sat dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .relu_en(relu_en),
    .bias_we(bias_we), .bias_waddr(bias_waddr), .bias_wdata(bias_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
    logic        s;
    logic        lat;
    logic [31:0] cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mbias [16];
  int   mch = 0;
  bit   bp_mode = 0;
  bit   lat_mode = 0;
  int   stall_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int d, input int b, input bit relu,
                                 input bit last);
    exp_t   e;
    longint s;
    s = longint'(d) + longint'(b);
    e = '0;
    if (relu && s < 0) s = 0;
    if (s > 32767) begin
      s = 32767; e.s = 1;
    end else if (s < -32768) begin
      s = -32768; e.s = 1;
    end
    e.d = s[15:0];
    e.l = last;
    return e;
  endfunction

  task automatic step(input bit v, input int d, input bit l, input bit r,
                      input bit we, input int wa, input int wd,
                      input bit clr, output bit acc);
    exp_t e;
    @(posedge clk); #1;
    in_valid   = v;
    in_data    = d;
    in_last    = l;
    relu_en    = r;
    bias_we    = we;
    bias_waddr = wa[3:0];
    bias_wdata = wd;
    sat_clr    = clr;
    if (stall_cycles > 0) begin
      out_ready = 1'b0;
      stall_cycles--;
    end else if (bp_mode) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
    #1;
    acc = v && in_ready;
    if (acc) begin
      e = model(d, mbias[mch], r, l);
      e.lat = lat_mode;
      e.cyc = cyc;
      q.push_back(e);
      mch = (l || mch == 15) ? 0 : mch + 1;
    end
    if (we) mbias[wa] = wd;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic wr(input int a, input int v);
    bit x;
    step(0, 0, 0, 0, 1, a, v, 0, x);
  endtask

  task automatic send(input int d, input bit l, input bit r);
    bit a;
    int n;
    a = 0;
    n = 0;
    while (!a && n < 100) begin
      step(1, d, l, r, 0, 0, 0, 0, a);
      n++;
    end
    if (!a) chk("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; in_valid = 0; bias_we = 0; sat_clr = 0;
    mch = 0;
    for (int i = 0; i < 16; i++) mbias[i] = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Monitor: pops on every output transfer, tracks sat_count and stalls.
  int   exp_sat = 0;
  bit   prev_stall = 0;
  bit   after_rst = 0;
  logic [15:0] held_d;
  logic held_l;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("sat_count", sat_count, exp_sat);
      if (after_rst) chk("out_valid_after_rst", out_valid, 0);
      after_rst = 0;
      if (prev_stall && !rst) begin
        chk("stall_valid_hold", out_valid, 1);
        chk("stall_data_hold", out_data, held_d);
        chk("stall_last_hold", out_last, held_l);
      end
      prev_stall = 0;
      if (rst) begin
        q.delete();
        exp_sat = 0;
        after_rst = 1;
      end else begin
        if (out_valid && !out_ready) begin
          chk("in_ready_stalled", in_ready, 0);
          prev_stall = 1;
          held_d = out_data;
          held_l = out_last;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("unexpected_output", out_data, -1);
          else begin
            e = q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_last", out_last, e.l);
            if (e.lat) chk("latency", cyc, e.cyc + 2);
            if (sat_clr) exp_sat = 0;
            else if (e.s && exp_sat != 16'hFFFF) exp_sat++;
          end
        end else if (sat_clr) exp_sat = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit   a;
    int   d, b;
    rst = 1; in_valid = 0; in_data = 0; in_last = 0; relu_en = 0;
    bias_we = 0; bias_waddr = 0; bias_wdata = 0;
    out_ready = 1; sat_clr = 0;
    for (int i = 0; i < 16; i++) mbias[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sat_count", sat_count, 0);

    // Latency
    wr(0, 100);
    lat_mode = 1;
    send(32512, 0, 0);
    lat_mode = 0;
    idle(3);

    // Saturation and clear-wins
    do_reset();
    send(40000, 0, 0);
    send(-40000, 0, 0);
    idle(3);
    @(negedge clk);
    chk("sat_after_two", sat_count, 2);
    send(40000, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 1, a);
    idle(2);
    @(negedge clk);
    chk("sat_clear_wins", sat_count, 0);

    // ReLU
    send(-5, 0, 1);
    send(-70000, 0, 1);
    send(-5, 0, 0);
    idle(3);

    // Backpressure
    do_reset();
    for (int i = 0; i < 16; i++) wr(i, i);
    send(1000, 0, 0);
    send(2000, 0, 0);
    stall_cycles = 5;
    send(3000, 0, 0);
    send(4000, 1, 0);
    idle(4);

    // Channel wrap and in_last
    do_reset();
    for (int i = 0; i < 16; i++) wr(i, i * 10);
    for (int i = 0; i < 17; i++) send(0, 0, 0);
    do_reset();
    for (int i = 0; i < 16; i++) wr(i, i * 10);
    for (int i = 0; i < 8; i++) send(0, i == 4, 0);
    idle(3);

    // Bias write hazard
    do_reset();
    wr(3, 1);
    for (int i = 0; i < 3; i++) send(0, 0, 0);
    step(1, 0, 0, 0, 1, 3, 7, 0, a);
    if (!a) chk("hazard_accept", a, 1);
    for (int i = 0; i < 15; i++) send(0, 0, 0);
    idle(3);

    // Reset mid-stream, then channel restarts at 0
    send(11, 0, 0);
    send(22, 0, 0);
    do_reset();
    for (int i = 0; i < 16; i++) wr(i, 1000 * (i + 1));
    send(5, 0, 0);
    send(6, 0, 0);
    idle(3);

    // Random stream
    bp_mode = 1;
    for (int n = 0; n < 300; n++) begin
      d = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                      : int'($urandom_range(0, 80000)) - 40000;
      if ($urandom_range(0, 5) == 0) begin
        b = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                        : int'($urandom_range(0, 20000)) - 10000;
        step(1, d, ($urandom_range(0, 7) == 0), $urandom_range(0, 1), 1,
             $urandom_range(0, 15), b, ($urandom_range(0, 15) == 0), a);
      end else if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        send(d, ($urandom_range(0, 7) == 0), $urandom_range(0, 1));
      end
    end
    bp_mode = 0;
    idle(8);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
